// File: rtl/sr_frame_rx.sv
// Serial frame receiver: start(1), DATA_W data bits LSB first, optional even parity, stop(0).
// Good words are held on a valid/ready port; parity, framing and overflow errors pulse for one clock.
module sr_frame_rx #(
    parameter int DATA_W    = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              si,
    input  logic              bit_en,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              par_err,
    output logic              frm_err,
    output logic              ovf
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] shreg_reg, shreg_next;
    logic              par_reg, par_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              valid_reg, valid_next;
    logic              par_err_reg, par_err_next;
    logic              frm_err_reg, frm_err_next;
    logic              ovf_reg, ovf_next;
    logic              frame_par_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            shreg_reg   <= '0;
            par_reg     <= 1'b0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            par_err_reg <= 1'b0;
            frm_err_reg <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            shreg_reg   <= shreg_next;
            par_reg     <= par_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            par_err_reg <= par_err_next;
            frm_err_reg <= frm_err_next;
            ovf_reg     <= ovf_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        shreg_next    = shreg_reg;
        par_next      = par_reg;
        data_next     = data_reg;
        valid_next    = valid_reg;
        par_err_next  = 1'b0;
        frm_err_next  = 1'b0;
        ovf_next      = 1'b0;
        frame_par_bad = PARITY_EN ? (^shreg_reg ^ par_reg) : 1'b0;

        // Downstream drains the held word regardless of the bit strobe.
        if (valid_reg && out_ready) begin
            valid_next = 1'b0;
        end

        if (bit_en) begin
            case (state_reg)
                IDLE: begin
                    if (si) begin
                        state_next = DATA;
                        cnt_next   = '0;
                    end
                end
                DATA: begin
                    shreg_next = {si, shreg_reg[DATA_W-1:1]};
                    if (cnt_reg == CNT_W'(DATA_W - 1)) begin
                        cnt_next   = '0;
                        state_next = PARITY_EN ? PARITY : STOP;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                PARITY: begin
                    par_next   = si;
                    state_next = STOP;
                end
                STOP: begin
                    // A high stop bit is a framing error, never a new start.
                    state_next   = IDLE;
                    frm_err_next = si;
                    par_err_next = frame_par_bad;
                    if (!si && !frame_par_bad) begin
                        if (!valid_reg || out_ready) begin
                            data_next  = shreg_reg;
                            valid_next = 1'b1;
                        end else begin
                            ovf_next = 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign out_data  = data_reg;
    assign out_valid = valid_reg;
    assign par_err   = par_err_reg;
    assign frm_err   = frm_err_reg;
    assign ovf       = ovf_reg;
endmodule

// File: tb/tb_sr_frame_rx.sv
// Bench for sr_frame_rx: directed frames plus random frames, checked against a frame-level model.
module tb_sr_frame_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       si = 1'b0;
    logic       bit_en = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, par_err, frm_err, ovf;

    int errors = 0;
    int checks = 0;

    // Frame-level reference model: the held word and its valid flag.
    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0;
    logic       e_par, e_frm, e_ovf;

    sr_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .si(si), .bit_en(bit_en), .out_ready(out_ready),
        .out_data(out_data), .out_valid(out_valid),
        .par_err(par_err), .frm_err(frm_err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int gap, input logic rdy);
        for (int g = 0; g < gap; g++) begin
            bit_en = 1'b0;
            @(posedge clk);
            #1;
        end
        bit_en    = 1'b1;
        si        = b;
        out_ready = rdy;
        @(posedge clk);
        #1;
        bit_en    = 1'b0;
        si        = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".par_err"}, par_err, e_par);
        check({tag, ".frm_err"}, frm_err, e_frm);
        check({tag, ".ovf"}, ovf, e_ovf);
        check({tag, ".valid"}, out_valid, m_valid);
        if (m_valid) check({tag, ".data"}, out_data, m_data);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] d, input logic p,
                              input logic stp, input int gap, input logic rdy);
        send_bit(1'b1, gap, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap, 1'b0);
        send_bit(p, gap, 1'b0);
        check({tag, ".prestop_valid"}, out_valid, m_valid);
        send_bit(stp, gap, rdy);
        e_frm = stp;
        e_par = (^d) ^ p;
        e_ovf = 1'b0;
        if (!e_frm && !e_par) begin
            if (!m_valid || rdy) begin
                m_data  = d;
                m_valid = 1'b1;
            end else begin
                e_ovf = 1'b1;
            end
        end else if (rdy && m_valid) begin
            m_valid = 1'b0;
        end
        check_outputs(tag);
        $display("frame %s d=%02h p=%0d stop=%0d rdy=%0d gap=%0d -> valid=%0d data=%02h pe=%0d fe=%0d ovf=%0d",
                 tag, d, p, stp, rdy, gap, out_valid, out_data, par_err, frm_err, ovf);
        // Pulses must drop on the next clock even without a strobe.
        @(posedge clk);
        #1;
        e_par = 1'b0; e_frm = 1'b0; e_ovf = 1'b0;
        check_outputs({tag, ".after"});
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        m_valid   = 1'b0;
        check({tag, ".drain_valid"}, out_valid, 1'b0);
        $display("drain %s -> valid=%0d", tag, out_valid);
    endtask

    initial begin
        logic [7:0] rd;
        logic       rp, rs, rr;
        int         rg;
        e_par = 1'b0; e_frm = 1'b0; e_ovf = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset.valid", out_valid, 1'b0);
        check("reset.data", out_data, 8'h00);
        check("reset.pulses", {par_err, frm_err, ovf}, 3'b000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Idle line with strobes must not start a frame
        for (int i = 0; i < 3; i++) send_bit(1'b0, 0, 1'b0);
        check_outputs("idle");

        // 1. good frame then drain
        send_frame("t1_A5", 8'hA5, 1'b0, 1'b0, 0, 1'b0);
        drain("t1");

        // 2. parity error, framing error, then clean frame right after
        send_frame("t2_par", 8'hA5, 1'b1, 1'b0, 0, 1'b0);
        send_frame("t2_frm", 8'h3C, 1'b0, 1'b1, 0, 1'b0);
        send_frame("t2_3C", 8'h3C, 1'b0, 1'b0, 0, 1'b0);
        drain("t2");

        // 3. overflow and simultaneous load/drain
        send_frame("t3_01", 8'h01, 1'b1, 1'b0, 0, 1'b0);
        send_frame("t3_02", 8'h02, 1'b1, 1'b0, 0, 1'b0);
        send_frame("t3_04", 8'h04, 1'b1, 1'b0, 0, 1'b1);
        drain("t3");

        // 4. strobe every third cycle
        send_frame("t4_5A", 8'h5A, 1'b0, 1'b0, 2, 1'b0);

        // 5. async reset mid-frame while a word is held
        send_bit(1'b1, 0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1 & (8'h77 >> i), 0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("t5.rst_valid", out_valid, 1'b0);
        check("t5.rst_data", out_data, 8'h00);
        check("t5.rst_pulses", {par_err, frm_err, ovf}, 3'b000);
        m_valid = 1'b0;
        m_data  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("t5.release");
        send_frame("t5_FF", 8'hFF, 1'b0, 1'b0, 0, 1'b0);
        drain("t5");

        // Random frames
        for (int n = 0; n < 40; n++) begin
            rd = 8'($urandom);
            rp = (^rd) ^ ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 3) == 0);
            rr = 1'($urandom);
            rg = $urandom_range(0, 2);
            for (int k = $urandom_range(0, 3); k > 0; k--) send_bit(1'b0, 0, 1'b0);
            send_frame($sformatf("rnd%0d", n), rd, rp, rs, rg, rr);
            if ($urandom_range(0, 3) == 0) drain($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
